// File: rtl/dh_pkg.sv
// Shared types and constants for the Duck Hunt control section.
package dh_pkg;

  // Width of the per-state frame timer; 600-frame flight timeout fits in 10 bits.
  localparam int unsigned TimerW = 10;

  typedef enum logic [2:0] {
    IDLE,
    BANNER,
    LAUNCH,
    FLIGHT,
    RESULT,
    OVER
  } round_state_t;

endpackage

// File: rtl/frame_timer.sv
// Saturating frame counter with synchronous clear; clear takes priority over count.
module frame_timer #(
  parameter int unsigned Width = 10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_d, count_q;

  // Next count: clear, else increment until all-ones.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/ctl_round.sv
// Game-round sequencer: schedules duck launches, refills ammo, tallies hits per round and
// decides round advance or game over.
module ctl_round
  import dh_pkg::*;
#(
  parameter int unsigned DUCKS_PER_ROUND = 10,
  parameter int unsigned NUM_ROUNDS      = 9,
  parameter int unsigned PASS_HITS       = 6,
  parameter int unsigned BANNER_FRAMES   = 120,
  parameter int unsigned LAUNCH_FRAMES   = 45,
  parameter int unsigned TIMEOUT_FRAMES  = 600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_frame,
  input  logic       pause,
  input  logic       reload,
  input  logic       hit,
  input  logic       duck_show,
  output logic       duck_launch,
  output logic       ammo_refill,
  output logic [3:0] round_num,
  output logic [3:0] round_hits,
  output logic [3:0] duck_idx,
  output logic       banner,
  output logic       game_over
);

  localparam logic [TimerW-1:0] BannerLast  = TimerW'(BANNER_FRAMES - 1);
  localparam logic [TimerW-1:0] LaunchLast  = TimerW'(LAUNCH_FRAMES - 1);
  localparam logic [TimerW-1:0] TimeoutLast = TimerW'(TIMEOUT_FRAMES - 1);
  localparam logic [3:0]        DucksMax    = 4'(DUCKS_PER_ROUND);
  localparam logic [3:0]        RoundsMax   = 4'(NUM_ROUNDS);
  localparam logic [3:0]        PassMin     = 4'(PASS_HITS);

  round_state_t state_d, state_q;
  logic [3:0]   round_d, round_q;
  logic [3:0]   hits_d, hits_q;
  logic [3:0]   idx_d, idx_q;
  logic         launch_d, launch_q;
  logic         banner_d, banner_q;
  logic         over_d, over_q;
  // Flight bookkeeping: duck seen on screen, and events captured while paused.
  logic         armed_d, armed_q;
  logic         hit_pend_d, hit_pend_q;
  logic         esc_pend_d, esc_pend_q;

  logic              tick;
  logic              timer_clear;
  logic [TimerW-1:0] timer;
  logic              hit_ev;
  logic              esc_ev;

  assign tick   = new_frame && !pause;
  assign hit_ev = hit || hit_pend_q;
  assign esc_ev = (armed_q && !duck_show) || esc_pend_q;

  // Timer restarts on every state entry, including BANNER re-entry via reload.
  assign timer_clear = (state_d != state_q) || reload;

  frame_timer #(
    .Width (TimerW)
  ) u_frame_timer (
    .clk_i   (clk),
    .rst_ni  (rst),
    .clear_i (timer_clear),
    .en_i    (tick),
    .count_o (timer)
  );

  // Next-state, counter updates and launch decision.
  always_comb begin
    state_d    = state_q;
    round_d    = round_q;
    hits_d     = hits_q;
    idx_d      = idx_q;
    launch_d   = 1'b0;
    armed_d    = armed_q;
    hit_pend_d = hit_pend_q;
    esc_pend_d = esc_pend_q;

    if (state_q != FLIGHT) begin
      armed_d    = 1'b0;
      hit_pend_d = 1'b0;
      esc_pend_d = 1'b0;
    end

    if (reload) begin
      state_d = BANNER;
      round_d = 4'd1;
      hits_d  = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: ;
        BANNER: begin
          if (tick && (timer == BannerLast)) state_d = LAUNCH;
        end
        LAUNCH: begin
          if (tick && (timer == LaunchLast)) begin
            state_d  = FLIGHT;
            launch_d = 1'b1;
            idx_d    = idx_q + 4'd1;
          end
        end
        FLIGHT: begin
          if (duck_show) armed_d = 1'b1;
          if (pause) begin
            // Hold state but remember what happened so it resolves on resume.
            if (hit) hit_pend_d = 1'b1;
            if (armed_q && !duck_show) esc_pend_d = 1'b1;
          end else if (hit_ev) begin
            state_d = RESULT;
            hits_d  = (hits_q == 4'hf) ? hits_q : hits_q + 4'd1;
          end else if (esc_ev) begin
            state_d = RESULT;
          end else if (tick && (timer == TimeoutLast)) begin
            state_d = RESULT;
          end
        end
        RESULT: begin
          if (!pause && !duck_show) begin
            if (idx_q < DucksMax) begin
              state_d = LAUNCH;
            end else if (hits_q < PassMin) begin
              state_d = OVER;
            end else if (round_q == RoundsMax) begin
              state_d = OVER;
            end else begin
              state_d = BANNER;
              round_d = round_q + 4'd1;
              hits_d  = '0;
              idx_d   = '0;
            end
          end
        end
        OVER: ;
        default: state_d = IDLE;
      endcase
    end

    banner_d = (state_d == BANNER);
    over_d   = (state_d == OVER);
  end

  // State, counter and registered-output flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      round_q    <= '0;
      hits_q     <= '0;
      idx_q      <= '0;
      launch_q   <= 1'b0;
      banner_q   <= 1'b0;
      over_q     <= 1'b0;
      armed_q    <= 1'b0;
      hit_pend_q <= 1'b0;
      esc_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      round_q    <= round_d;
      hits_q     <= hits_d;
      idx_q      <= idx_d;
      launch_q   <= launch_d;
      banner_q   <= banner_d;
      over_q     <= over_d;
      armed_q    <= armed_d;
      hit_pend_q <= hit_pend_d;
      esc_pend_q <= esc_pend_d;
    end
  end

  assign duck_launch = launch_q;
  assign ammo_refill = launch_q;
  assign round_num   = round_q;
  assign round_hits  = hits_q;
  assign duck_idx    = idx_q;
  assign banner      = banner_q;
  assign game_over   = over_q;

endmodule
